// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with a valid/ready request side and a valid/ready result side.
// ADD, SUB, RESET and unlisted codes complete in one cycle.
// MUL, COUNT_ONES and LEADING_ONES iterate one bit per cycle.
// Optional build macro SEQ_ALU_EARLY_EXIT_EN: LEADING_ONES stops at the first 0 bit it examines.

package types_pkg;
    typedef enum logic [2:0] {
        RESET        = 3'd0,
        ADD          = 3'd1,
        SUB          = 3'd2,
        MUL          = 3'd3,
        LEADING_ONES = 3'd4,
        COUNT_ONES   = 3'd5
    } opr_mode_t;
endpackage

module seq_alu
    import types_pkg::*;
#(
    parameter int BITS = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  opr_mode_t       SELECTOR,
    input  logic [BITS-1:0] SW,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [BITS-1:0] LED,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int HALF = BITS / 2;
    localparam int CW   = $clog2(BITS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    opr_mode_t       op;
    logic [BITS-1:0] opnd;
    logic [BITS-1:0] mcand;
    logic [BITS-1:0] acc;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   limit;
    logic            halt;

    logic [BITS-1:0] lh_ext;
    logic [BITS-1:0] rh_ext;
    logic [BITS-1:0] quick;
    logic            multi;
    logic [BITS-1:0] acc_next;
    logic            stop_now;
    logic            last;
    logic            finish;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Operand halves and the single-cycle results, computed straight from the request inputs.
    always_comb begin
        lh_ext = {{(BITS-HALF){1'b0}}, SW[BITS-1:HALF]};
        rh_ext = {{(BITS-HALF){1'b0}}, SW[HALF-1:0]};
        quick  = '0;
        multi  = 1'b0;
        case (SELECTOR)
            ADD:          quick = lh_ext + rh_ext;
            SUB:          quick = lh_ext - rh_ext;
            MUL:          multi = 1'b1;
            LEADING_ONES: multi = 1'b1;
            COUNT_ONES:   multi = 1'b1;
            default:      quick = '0;
        endcase
    end

    // One iteration step of the captured operation; the last step is written straight to LED.
    always_comb begin
        acc_next = acc;
        stop_now = 1'b0;
        case (op)
            MUL: begin
                if (opnd[0]) begin
                    acc_next = acc + mcand;
                end
            end
            COUNT_ONES: begin
                acc_next = acc + {{(BITS-1){1'b0}}, opnd[0]};
            end
            LEADING_ONES: begin
                if (!halt && opnd[BITS-1]) begin
                    acc_next = acc + BITS'(1);
                end
                stop_now = !opnd[BITS-1];
            end
            default: acc_next = acc;
        endcase
    end

    assign last = (cnt == limit);
`ifdef SEQ_ALU_EARLY_EXIT_EN
    assign finish = last || stop_now;
`else
    assign finish = last;
`endif

    // Control FSM and datapath registers; a reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            op    <= RESET;
            opnd  <= '0;
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            limit <= '0;
            halt  <= 1'b0;
            LED   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op    <= SELECTOR;
                        cnt   <= '0;
                        acc   <= '0;
                        halt  <= 1'b0;
                        mcand <= lh_ext;
                        opnd  <= (SELECTOR == MUL) ? rh_ext : SW;
                        limit <= (SELECTOR == MUL) ? CW'(HALF-1) : CW'(BITS-1);
                        if (multi) begin
                            state <= BUSY;
                        end else begin
                            LED   <= quick;
                            state <= DONE;
                        end
                    end
                end
                BUSY: begin
                    acc  <= acc_next;
                    cnt  <= cnt + CW'(1);
                    halt <= halt | stop_now;
                    if (op == LEADING_ONES) begin
                        opnd <= opnd << 1;
                    end else begin
                        opnd <= opnd >> 1;
                    end
                    mcand <= mcand << 1;
                    if (finish) begin
                        LED   <= acc_next;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu (BITS = 16).
// The driver pushes hand-computed expectations; the monitor pops one per rising out_valid.
// Define SEQ_ALU_EARLY_EXIT_EN for both the bench and the design to check the early-exit build.

module tb_seq_alu;
    import types_pkg::*;

    localparam int BITS = 16;

    logic            clk = 1'b0;
    logic            rst;
    opr_mode_t       sel;
    logic [BITS-1:0] sw;
    logic            in_valid;
    logic            in_ready;
    logic [BITS-1:0] led;
    logic            out_valid;
    logic            out_ready;

    typedef struct {
        logic [BITS-1:0] led;
        int              lat;
        int              acc_cyc;
        string           name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   fails  = 0;

`ifdef SEQ_ALU_EARLY_EXIT_EN
    localparam int LO_F0FF_LAT = 6;
    localparam int LO_7FFF_LAT = 2;
`else
    localparam int LO_F0FF_LAT = 17;
    localparam int LO_7FFF_LAT = 17;
`endif

    seq_alu #(.BITS(BITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .SELECTOR  (sel),
        .SW        (sw),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .LED       (led),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Edge counter, read only at falling edges.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Present one request, wait for the accept edge, scramble the inputs, record the expectation.
    task automatic applyStimulus(input opr_mode_t op, input logic [BITS-1:0] s,
                                 input logic [BITS-1:0] e_led, input int e_lat,
                                 input string name, input bit track);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        @(negedge clk);
        sel      = op;
        sw       = s;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checkOutput({name, "_accept"}, in_ready, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        sel      = ADD;
        sw       = 16'hA5C3;
        if (track) begin
            e.led     = e_led;
            e.lat     = e_lat;
            e.acc_cyc = cyc;
            e.name    = name;
            sb.push_back(e);
        end
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #2;
            if (sb.size() == 0 && in_ready) return;
        end
        checkOutput("drain_timeout", sb.size(), 0);
    endtask

    // Monitor: one scoreboard pop per new result, LED stability checked while a result is held.
    initial begin
        logic            prev;
        logic [BITS-1:0] held;
        exp_t            e;
        prev = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (out_valid && !prev) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_result", out_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput({e.name, "_led"}, led, e.led);
                        checkOutput({e.name, "_latency"}, cyc - e.acc_cyc + 1, e.lat);
                    end
                    held = led;
                end else if (out_valid && prev) begin
                    checkOutput("hold_led", led, held);
                end
                prev = out_valid;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a1;
        int a2;
        bit ok;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sel       = RESET;
        sw        = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_led", led, 0);
        checkOutput("reset_out_valid", out_valid, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", in_ready, 1);

        applyStimulus(ADD, 16'h0305, 16'h0008, 1, "add_0305", 1'b1);
        waitIdle();
        applyStimulus(SUB, 16'h0305, 16'hFFFE, 1, "sub_0305", 1'b1);
        waitIdle();
        applyStimulus(ADD, 16'hFFFF, 16'h01FE, 1, "add_ffff", 1'b1);
        waitIdle();
        applyStimulus(SUB, 16'h0503, 16'h0002, 1, "sub_0503", 1'b1);
        waitIdle();
        applyStimulus(RESET, 16'hFFFF, 16'h0000, 1, "reset_op", 1'b1);
        waitIdle();
        applyStimulus(MUL, 16'hFFFF, 16'hFE01, 9, "mul_ffff", 1'b1);
        waitIdle();
        applyStimulus(opr_mode_t'(3'd7), 16'h1234, 16'h0000, 1, "unlisted_op", 1'b1);
        waitIdle();
        applyStimulus(MUL, 16'h0C0A, 16'h0078, 9, "mul_0c0a", 1'b1);
        waitIdle();
        applyStimulus(COUNT_ONES, 16'hF0FF, 16'd12, 17, "count_f0ff", 1'b1);
        waitIdle();
        applyStimulus(COUNT_ONES, 16'h0000, 16'd0, 17, "count_0000", 1'b1);
        waitIdle();
        applyStimulus(LEADING_ONES, 16'hF0FF, 16'd4, LO_F0FF_LAT, "lead_f0ff", 1'b1);
        waitIdle();
        applyStimulus(LEADING_ONES, 16'hFFFF, 16'd16, 17, "lead_ffff", 1'b1);
        waitIdle();
        applyStimulus(LEADING_ONES, 16'h7FFF, 16'd0, LO_7FFF_LAT, "lead_7fff", 1'b1);
        waitIdle();

        // Result held in DONE while the consumer stalls; request pulses must be ignored.
        out_ready = 1'b0;
        applyStimulus(MUL, 16'hFFFF, 16'hFE01, 9, "mul_hold", 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            #2;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("hold_reached_done", out_valid, 1);
        repeat (5) begin
            @(negedge clk);
            in_valid = ~in_valid;
            sel      = ADD;
            checkOutput("hold_in_ready", in_ready, 0);
            checkOutput("hold_out_valid", out_valid, 1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("release_out_valid", out_valid, 0);
        checkOutput("release_in_ready", in_ready, 1);
        checkOutput("release_led", led, 16'hFE01);
        waitIdle();

        // Reset during a multiply aborts it with no result afterwards.
        applyStimulus(MUL, 16'h0C0A, 16'h0078, 9, "mul_abort", 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("abort_led", led, 0);
        checkOutput("abort_out_valid", out_valid, 0);
        sw  = 16'h1234;
        sel = COUNT_ONES;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("abort_in_ready", in_ready, 1);
        repeat (30) @(negedge clk);
        checkOutput("abort_no_result", out_valid, 0);
        checkOutput("abort_led_after", led, 0);

        // Back-to-back ADD then SUB with in_valid held high.
        @(negedge clk);
        sel      = ADD;
        sw       = 16'h0305;
        in_valid = 1'b1;
        checkOutput("b2b_ready_first", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        a1 = cyc;
        sb.push_back('{16'h0008, 1, cyc, "b2b_add"});
        sel = SUB;
        checkOutput("b2b_busy_in_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b_idle_in_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        a2 = cyc;
        sb.push_back('{16'hFFFE, 1, cyc, "b2b_sub"});
        in_valid = 1'b0;
        checkOutput("b2b_accept_spacing", a2 - a1, 2);
        waitIdle();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter: BITS, 16, data width of SW and LED; even, >= 4; LH = SW[BITS-1:BITS/2], RH = SW[BITS/2-1:0].
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: SELECTOR  input  opr_mode_t  operation code from types_pkg (RESET, ADD, SUB, MUL, LEADING_ONES, COUNT_ONES).
REQ-005 SHALL have port: SW  input  BITS  operand word.
REQ-006 SHALL have port: in_valid  input  1  request present.
REQ-007 SHALL have port: in_ready  output  1  block can accept a request.
REQ-008 SHALL have port: LED  output  BITS  registered result.
REQ-009 SHALL have port: out_valid  output  1  LED holds a completed result.
REQ-010 SHALL have port: out_ready  input  1  consumer takes the result.

Function
REQ-011 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-012 SHALL accept a request on an edge with in_valid & in_ready, capturing SW and SELECTOR into internal registers; later SW/SELECTOR changes do not affect that operation.
REQ-013 SHALL count latency from the accept edge to the edge at which out_valid becomes 1: RESET/ADD/SUB/unlisted codes 1; MUL BITS/2+1; COUNT_ONES BITS+1; LEADING_ONES per REQ-024.
REQ-014 SHALL go IDLE -> DONE directly for 1-cycle operations and IDLE -> BUSY otherwise.
REQ-015 ADD: LED = zero-extended LH + RH (BITS/2+1 bits; never overflows BITS).
REQ-016 SUB: LED = (LH - RH) mod 2^BITS, i.e. BITS-bit two's complement.
REQ-017 MUL: iterative shift-add, one RH bit per cycle, LSB first; LED = full BITS-bit unsigned product LH*RH.
REQ-018 COUNT_ONES: one SW bit per cycle; LED = number of 1 bits in the full BITS-bit SW.
REQ-019 LEADING_ONES: scan from SW[BITS-1] downward, one bit per cycle; LED = count of consecutive 1s before the first 0 (BITS if all ones).
REQ-020 RESET code and unlisted codes: LED = 0.
REQ-021 In DONE, LED and out_valid SHALL hold stable until out_ready = 1; on that edge the block returns to IDLE with out_valid = 0 and LED unchanged.
REQ-022 SHALL NOT accept a new request on the same edge as the DONE -> IDLE handoff (in_ready is 0 in DONE); earliest next accept is the following edge.
REQ-023 LED SHALL change only on the edge entering DONE, never mid-computation.

Reset
REQ-024 (see Configuration for LEADING_ONES latency.)
REQ-025 On rst = 1, asynchronously: state = IDLE, LED = 0, out_valid = 0, in_ready = 1 once rst deasserts, all iteration counters and captured operands cleared.
REQ-026 Reset asserted mid-operation SHALL abort it; no result is emitted afterwards.

Configuration
REQ-027 Macro SEQ_ALU_EARLY_EXIT_EN: when defined, LEADING_ONES stops after examining the first 0 bit; latency = min(k+1, BITS)+1 where k = result.
REQ-028 Without SEQ_ALU_EARLY_EXIT_EN, LEADING_ONES always examines all BITS bits; latency = BITS+1; LED values are identical in both builds.

Verification (BITS = 16)
REQ-029 ADD, SW=16'h0305, out_ready=1 -> out_valid one cycle after accept, LED = 16'h0008.
REQ-030 SUB, SW=16'h0305 -> LED = 16'hFFFE after 1 cycle; MUL, SW=16'hFFFF -> LED = 16'hFE01 exactly 9 cycles after accept.
REQ-031 COUNT_ONES, SW=16'hF0FF -> LED = 12 after 17 cycles; LEADING_ONES same SW -> LED = 4 after 17 cycles (macro off) or 6 cycles (macro on).
REQ-032 Any op with out_ready held 0 for 5 cycles in DONE -> LED, out_valid stable, in_ready = 0, in_valid pulses ignored; release -> IDLE next edge.
REQ-033 MUL accepted, rst pulsed 4 cycles later, then SW changed -> LED = 0, out_valid = 0, in_ready = 1 after rst release, no stale result.
REQ-034 Back-to-back ADD then SUB with in_valid held 1 and out_ready = 1 -> second accept occurs 2 edges after first, results 16'h0008 then 16'hFFFE in order.
